// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default parameter values for the synchronous FIFO.
package fifo_pkg;

    localparam int DEF_BITS  = 8;
    localparam int DEF_DEPTH = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_ptr.sv
// Wrap-around pointer counter with increment enable and synchronous reset.
module fifo_sync_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Natural binary overflow provides the DEPTH-1 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + W'(1);
    end

endmodule

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO with registered count and flags.
// Define FIFO_SYNC_ERR_EN to add sticky ovf/udf error outputs.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int BITS   = DEF_BITS,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [BITS-1:0]           Din,
    output logic [BITS-1:0]           Dout,
    output logic                      full,
    output logic                      pndng,
    output logic                      almost_full,
    output logic                      almost_empty,
`ifdef FIFO_SYNC_ERR_EN
    output logic                      ovf,
    output logic                      udf,
`endif
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    // A push into a full FIFO is still taken when a pop frees the head slot.
    always_comb begin
        pop_ok  = pop & pndng;
        push_ok = push & (~full | pop);
    end

    fifo_sync_ptr #(.W(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_ok),
        .ptr (wr_ptr)
    );

    fifo_sync_ptr #(.W(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_ok),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push_ok && !rst)
            mem[wr_ptr] <= Din;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (push_ok && !pop_ok)
            count <= count + CW'(1);
        else if (pop_ok && !push_ok)
            count <= count - CW'(1);
    end

    always_comb begin
        full         = (count == DEPTH_C);
        pndng        = (count != '0);
        almost_full  = (count >= AF_C);
        almost_empty = (count <= AE_C);
        Dout         = pndng ? mem[rd_ptr] : '0;
    end

`ifdef FIFO_SYNC_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push && full && !pop)
                ovf <= 1'b1;
            if (pop && !pndng)
                udf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: vector table, corner sequences, random run vs queue model.
module tb_fifo_sync;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] Din = '0;
    logic [7:0] Dout;
    logic       full, pndng, almost_full, almost_empty;
    logic [3:0] count;
`ifdef FIFO_SYNC_ERR_EN
    logic       ovf, udf;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    always #5 clk = ~clk;

    fifo_sync #(.BITS(8), .DEPTH(DEPTH), .AF_LVL(6), .AE_LVL(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .Din          (Din),
        .Dout         (Dout),
        .full         (full),
        .pndng        (pndng),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_SYNC_ERR_EN
        .ovf          (ovf),
        .udf          (udf),
`endif
        .count        (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("pndng", 32'(pndng), 32'(n != 0));
        chk("almost_full", 32'(almost_full), 32'(n >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("dout", 32'(Dout), (n != 0) ? 32'(mq[0]) : 32'h0);
`ifdef FIFO_SYNC_ERR_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("udf", 32'(udf), 32'(m_udf));
`endif
    endtask

    // Reference rules: a pop needs data; a push needs room, or a simultaneous pop.
    task automatic model_step(input logic p, input logic q, input logic [7:0] d);
        bit pop_ok, push_ok;
        pop_ok  = q && (mq.size() > 0);
        push_ok = p && ((mq.size() < DEPTH) || q);
        if (p && !q && mq.size() == DEPTH) m_ovf = 1'b1;
        if (q && mq.size() == 0) m_udf = 1'b1;
        if (pop_ok) void'(mq.pop_front());
        if (push_ok) mq.push_back(d);
    endtask

    task automatic cycle(input logic p, input logic q, input logic [7:0] d);
        push = p; pop = q; Din = d;
        if (q && mq.size() > 0) chk("read_data", 32'(Dout), 32'(mq[0]));
        @(posedge clk); #1;
        model_step(p, q, d);
        check_all();
    endtask

    task automatic do_reset(input logic p);
        rst = 1'b1; push = p; pop = 1'b0; Din = 8'hEE;
        @(posedge clk); #1;
        rst = 1'b0; push = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_all();
    endtask

    typedef struct {
        logic       p;
        logic       q;
        logic [7:0] d;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic [3:0] exp_count;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] last_rd;

        vecs[0] = '{1'b1, 1'b0, 8'hA1, 1'b0, 8'h00, 4'd1, 8'hA1};
        vecs[1] = '{1'b1, 1'b0, 8'hB2, 1'b0, 8'h00, 4'd2, 8'hA1};
        vecs[2] = '{1'b1, 1'b0, 8'hC3, 1'b0, 8'h00, 4'd3, 8'hA1};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hA1, 4'd2, 8'hB2};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hB2, 4'd1, 8'hC3};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hC3, 4'd0, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 4'd1, 8'h3C};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h3C, 4'd0, 8'h00};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        // Basic ordering and empty push+pop
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].chk_rd) chk("vec_rd", 32'(Dout), 32'(vecs[i].exp_rd));
            cycle(vecs[i].p, vecs[i].q, vecs[i].d);
            chk("vec_count", 32'(count), 32'(vecs[i].exp_count));
            chk("vec_dout", 32'(Dout), 32'(vecs[i].exp_dout));
`ifdef FIFO_SYNC_ERR_EN
            if (i == 6) chk("vec_udf", 32'(udf), 32'h1);
`endif
        end

        // Overflow: ninth push dropped
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i));
        cycle(1'b1, 1'b0, 8'hFF);
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_count", 32'(count), 32'd8);
`ifdef FIFO_SYNC_ERR_EN
        chk("ovf_flag", 32'(ovf), 32'h1);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_no_ff", 32'(Dout == 8'hFF), 32'h0);
            cycle(1'b0, 1'b1, 8'h00);
        end

        // Full push+pop replaces freed slot
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i));
        cycle(1'b1, 1'b1, 8'h55);
        chk("fullpp_count", 32'(count), 32'd8);
        last_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            last_rd = Dout;
            cycle(1'b0, 1'b1, 8'h00);
        end
        chk("fullpp_last", 32'(last_rd), 32'h55);

        // Reset with push pending at count 5
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
        do_reset(1'b1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pndng", 32'(pndng), 32'h0);
        chk("rst_dout", 32'(Dout), 32'h0);
        cycle(1'b1, 1'b0, 8'h77);
        chk("rst_fresh", 32'(Dout), 32'h77);

        // Random traffic with fill/drain bias phases for wrap and flag coverage
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 50) % 3;
            case (bias)
                0: cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 8'($urandom));
                1: cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
                default: cycle(1'($urandom), 1'($urandom), 8'($urandom));
            endcase
            if (i == 200) do_reset(1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 The module SHALL have parameter BITS, default 8, data word width in bits (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 8, number of storage entries (power of two, >=2).
REQ-003 The module SHALL have parameter AF_LVL, default DEPTH-1, count at or above which almost_full asserts.
REQ-004 The module SHALL have parameter AE_LVL, default 1, count at or below which almost_empty asserts.
REQ-005 The module SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 The module SHALL have port push  input  1  write request.
REQ-008 The module SHALL have port pop  input  1  read request.
REQ-009 The module SHALL have port Din  input  BITS  write data.
REQ-010 The module SHALL have port Dout  output  BITS  head-of-queue data (first-word-fall-through).
REQ-011 The module SHALL have port full  output  1  count == DEPTH.
REQ-012 The module SHALL have port pndng  output  1  count != 0 (unread data present).
REQ-013 The module SHALL have port almost_full  output  1  count >= AF_LVL.
REQ-014 The module SHALL have port almost_empty  output  1  count <= AE_LVL.
REQ-015 The module SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-016 Push SHALL be accepted when push=1 and (full=0 or pop=1); Din written at wr_ptr; wr_ptr advances by one.
REQ-017 Pop SHALL be accepted when pop=1 and pndng=1; rd_ptr advances by one.
REQ-018 Push while full with pop=0 SHALL be dropped; storage, pointers, count unchanged.
REQ-019 Pop while empty SHALL be ignored, including when push=1 in the same cycle (push alone accepted, count 0->1).
REQ-020 Push and pop both accepted SHALL leave count unchanged; when full, the freed slot receives Din.
REQ-021 Pointers SHALL be $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 without extra logic.
REQ-022 count SHALL update on the edge after an accepted operation: +1 push only, -1 pop only, else hold.
REQ-023 Flags full, pndng, almost_full, almost_empty SHALL be decoded from the registered count (no combinational path from push/pop).
REQ-024 Dout SHALL equal mem[rd_ptr] when pndng=1 and all-zeros when pndng=0; written data visible on Dout one cycle after push into an empty FIFO.
REQ-025 Read latency SHALL be zero: data on Dout is consumed by the pop in that same cycle.

Reset
REQ-026 With rst=1 at a rising clk edge, wr_ptr, rd_ptr and count SHALL become 0, so full=0, pndng=0, almost_full=(AF_LVL==0), almost_empty=1, Dout=0.
REQ-027 Reset SHALL take precedence over push/pop in the same cycle; storage array contents need not be cleared.
REQ-028 Reset mid-operation SHALL discard all queued entries; no stale word SHALL appear on Dout afterwards.

Configuration
REQ-029 Macro FIFO_SYNC_ERR_EN, when defined, SHALL add output ports ovf and udf (1 bit each), sticky-high after a dropped push (REQ-018) or ignored pop (REQ-019), cleared only by rst.
REQ-030 Without FIFO_SYNC_ERR_EN, ports ovf/udf and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package fifo_pkg SHALL hold the pointer-width and count-width helper constants/functions and the default BITS/DEPTH values.
REQ-032 A sub-module fifo_sync_ptr SHALL implement one wrap-around pointer counter (inc enable, synchronous reset), instantiated for wr_ptr and rd_ptr.

Verification
REQ-033 Bench: rst, then push 0xA1,0xB2,0xC3 -> count=3, Dout=0xA1; three pops give 0xA1,0xB2,0xC3, then pndng=0, Dout=0x00.
REQ-034 Bench: DEPTH=8, push 8 words, 9th push of 0xFF -> full=1, count=8, 0xFF never read; with ERR_EN ovf=1.
REQ-035 Bench: full FIFO, push=1 pop=1 with Din=0x55 -> count stays 8; after 8 more pops, last word read is 0x55.
REQ-036 Bench: empty FIFO, push=1 pop=1 Din=0x3C -> count=1, Dout=0x3C next cycle; with ERR_EN udf=1.
REQ-037 Bench: AF_LVL=6, AE_LVL=2 -> almost_empty=1 for count 0..2, almost_full=1 for count 6..8; 20 push/pop cycles exercise pointer wrap.
REQ-038 Bench: rst=1 at count=5 with push=1 -> next cycle count=0, pndng=0, Dout=0x00.
